// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared definitions for the pipeline hazard/stall sequencer:
//            sequencer state encoding, register-zero constant, default
//            memory timeout and the load-use hazard detection helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEF_MEM_TIMEOUT = 16;

  // A load into $0 never creates a real dependency, so it is excluded.
  function automatic logic load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl_if
// Purpose  : Bundle of pipeline status inputs, data-memory handshake and
//            pipeline control outputs of the hazard/stall sequencer.
// Ports    : master - sequencer side (drives controls, dmem_req, counters)
//            slave  - pipeline / data memory side
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  // pipeline status
  logic             id_ex_MemRead;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             ex_mem_MemRead;
  logic             ex_mem_MemWrite;
  logic             ex_mem_Branch;
  logic             ex_mem_zero;
  // data memory handshake
  logic             dmem_ready;
  logic             dmem_req;
  // pipeline controls
  logic             pc_write;
  logic             if_id_write;
  logic             pc_src;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             ex_mem_stall;
  // debug / status
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  id_ex_MemRead, id_ex_rt, if_id_rs, if_id_rt,
    input  ex_mem_MemRead, ex_mem_MemWrite, ex_mem_Branch, ex_mem_zero,
    input  dmem_ready,
    output dmem_req, pc_write, if_id_write, pc_src, id_ex_bubble,
    output if_id_flush, id_ex_flush, ex_mem_flush, ex_mem_stall,
    output mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    output id_ex_MemRead, id_ex_rt, if_id_rs, if_id_rt,
    output ex_mem_MemRead, ex_mem_MemWrite, ex_mem_Branch, ex_mem_zero,
    output dmem_ready,
    input  dmem_req, pc_write, if_id_write, pc_src, id_ex_bubble,
    input  if_id_flush, id_ex_flush, ex_mem_flush, ex_mem_stall,
    input  mem_err, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating event counter; sticks at all-ones instead of wrapping.
//            Updates on the falling clock edge like the pipeline registers.
// Ports    : clk   - clock (falling edge active)
//            rst_n - asynchronous active-low reset
//            inc   - count one event this cycle
//            clr   - synchronous clear (wins over inc)
//            q     - current count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign q = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Central sequencer of the 5-stage pipeline. Each cycle decides
//            whether the pipeline advances, holds (multi-cycle data-memory
//            access), bubbles (load-use hazard) or flushes (taken branch).
//            Keeps saturating stall/flush counters and a sticky timeout
//            error. State updates on the falling clock edge.
// Ports    : clk   - pipeline clock (falling edge active)
//            rst_n - asynchronous active-low reset
//            bus   - hazard_stall_ctrl_if.master: pipeline status in,
//                    dmem handshake, pipeline controls and debug counters out
// Params   : MEM_TIMEOUT - max MEM_WAIT cycles before the error state
//            CNT_W       - counter width (must match the interface CNT_W)
//            TO_W        - wait counter width, 2**TO_W > MEM_TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 16,
  parameter int TO_W        = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_stall_ctrl_if.master bus
);

  localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(MEM_TIMEOUT);

  hz_state_e       state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic            err_q, err_d;

  logic mem_op;
  logic taken;
  logic hazard;
  logic hold;      // pipeline frozen this cycle
  logic decode;    // normal branch/hazard priority applies this cycle

  logic pc_write, if_id_write, pc_src, id_ex_bubble;
  logic stage_flush;

  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  assign mem_op = bus.ex_mem_MemRead | bus.ex_mem_MemWrite;
  assign taken  = bus.ex_mem_Branch & bus.ex_mem_zero;
  assign hazard = load_use(bus.id_ex_MemRead, bus.id_ex_rt,
                           bus.if_id_rs, bus.if_id_rt);

  // Next-state logic. RUN also catches the unused encoding and steers it
  // back to RUN.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    hold    = 1'b0;
    decode  = 1'b0;
    case (state_q)
      ST_MEM_WAIT: begin
        if (bus.dmem_ready) begin
          // Access completes: release in this same cycle so the next
          // falling edge already advances the pipeline.
          decode  = 1'b1;
          state_d = ST_RUN;
          wait_d  = '0;
        end else begin
          hold = 1'b1;
          if (wait_q == TIMEOUT_C) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            wait_d = wait_q + TO_W'(1);
          end
        end
      end
      ST_ERR: begin
        hold  = 1'b1;
        err_d = 1'b1;
      end
      default: begin
        if (mem_op && !bus.dmem_ready) begin
          // Memory stall outranks branch and load-use; the branch is
          // re-evaluated once the wait releases.
          hold    = 1'b1;
          state_d = ST_MEM_WAIT;
          wait_d  = TO_W'(1);
        end else begin
          decode  = 1'b1;
          state_d = ST_RUN;
          wait_d  = '0;
        end
      end
    endcase
  end

  // Control decode. A taken branch squashes the instructions involved in
  // any load-use hazard, so the hazard check is skipped under a branch.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    pc_src       = 1'b0;
    id_ex_bubble = 1'b0;
    stage_flush  = 1'b0;
    if (decode) begin
      if (taken) begin
        pc_src      = 1'b1;
        stage_flush = 1'b1;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end else if (hazard) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_write),
    .clr   (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stage_flush),
    .clr   (1'b0),
    .q     (flush_cnt)
  );

  assign bus.dmem_req     = mem_op & (state_q != ST_ERR);
  assign bus.pc_write     = pc_write;
  assign bus.if_id_write  = if_id_write;
  assign bus.pc_src       = pc_src;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.if_id_flush  = stage_flush;
  assign bus.id_ex_flush  = stage_flush;
  assign bus.ex_mem_flush = stage_flush;
  assign bus.ex_mem_stall = hold;
  assign bus.mem_err      = err_q;
  assign bus.stall_cnt    = stall_cnt;
  assign bus.flush_cnt    = flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Self-checking bench for hazard_stall_ctrl. Directed scenarios
//            followed by randomized traffic, all compared cycle by cycle
//            against a behavioural model of the sequencing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;
  import hazard_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;
  localparam int TB_TO_W    = 3;
  localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

  logic clk   = 1'b1;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

  hazard_stall_ctrl #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W),
    .TO_W        (TB_TO_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_wait;    // cycles spent waiting on memory, 0 = not waiting
  bit m_err;
  int m_stall;
  int m_flush;

  // expected outputs for the current cycle
  bit e_frozen, e_taken, e_lu, e_req;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_outputs();
    bit mem_op;
    bit rdy;
    mem_op   = bus.ex_mem_MemRead || bus.ex_mem_MemWrite;
    rdy      = bus.dmem_ready;
    e_frozen = m_err || (!rdy && (m_wait > 0 || mem_op));
    e_taken  = !e_frozen && bus.ex_mem_Branch && bus.ex_mem_zero;
    e_lu     = !e_frozen && !e_taken && bus.id_ex_MemRead &&
               (bus.id_ex_rt != 5'd0) &&
               (bus.id_ex_rt == bus.if_id_rs || bus.id_ex_rt == bus.if_id_rt);
    e_req    = mem_op && !m_err;
  endtask

  task automatic model_advance();
    bit mem_op;
    mem_op = bus.ex_mem_MemRead || bus.ex_mem_MemWrite;
    if ((e_frozen || e_lu) && m_stall < CNT_MAX) m_stall++;
    if (e_taken && m_flush < CNT_MAX) m_flush++;
    if (!m_err) begin
      if (m_wait > 0) begin
        if (bus.dmem_ready)             m_wait = 0;
        else if (m_wait == TB_TIMEOUT)  m_err  = 1'b1;
        else                            m_wait++;
      end else if (mem_op && !bus.dmem_ready) begin
        m_wait = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, let them settle, compare against the model.
  task automatic apply(input bit lmr, input logic [4:0] ert,
                       input logic [4:0] irs, input logic [4:0] irt,
                       input bit mr, input bit mw, input bit br,
                       input bit z, input bit rdy);
    logic [7:0] exp_ctrl;
    logic [7:0] obs_ctrl;
    bus.id_ex_MemRead   = lmr;
    bus.id_ex_rt        = ert;
    bus.if_id_rs        = irs;
    bus.if_id_rt        = irt;
    bus.ex_mem_MemRead  = mr;
    bus.ex_mem_MemWrite = mw;
    bus.ex_mem_Branch   = br;
    bus.ex_mem_zero     = z;
    bus.dmem_ready      = rdy;
    #3;
    model_outputs();
    exp_ctrl = {!(e_frozen || e_lu), e_taken, e_lu, e_taken, e_taken,
                e_taken, e_frozen, e_req};
    obs_ctrl = {bus.pc_write, bus.pc_src, bus.id_ex_bubble, bus.if_id_flush,
                bus.id_ex_flush, bus.ex_mem_flush, bus.ex_mem_stall,
                bus.dmem_req};
    check("ctrl", 32'(obs_ctrl), 32'(exp_ctrl));
    if (!e_taken)
      check("if_id_write", 32'(bus.if_id_write), 32'(!(e_frozen || e_lu)));
    check("mem_err", 32'(bus.mem_err), 32'(m_err));
    check("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
  endtask

  task automatic tick();
    @(negedge clk);
    model_advance();
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    bus.ex_mem_MemRead  = 1'b0;
    bus.ex_mem_MemWrite = 1'b0;
    bus.ex_mem_Branch   = 1'b0;
    bus.id_ex_MemRead   = 1'b0;
    rst_n = 1'b0;
    #2;
    m_wait  = 0;
    m_err   = 1'b0;
    m_stall = 0;
    m_flush = 0;
    check("rst_mem_err", 32'(bus.mem_err), 32'd0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd7;
    bus.id_ex_MemRead = 1'b0; bus.id_ex_rt = 5'd0; bus.if_id_rs = 5'd0;
    bus.if_id_rt = 5'd0; bus.ex_mem_MemRead = 1'b0; bus.ex_mem_MemWrite = 1'b0;
    bus.ex_mem_Branch = 1'b0; bus.ex_mem_zero = 1'b0; bus.dmem_ready = 1'b1;
    #1;

    // reset state
    do_reset();
    idle();
    check("reset_pc_write", 32'(bus.pc_write), 32'd1);
    check("reset_if_id_write", 32'(bus.if_id_write), 32'd1);
    check("reset_flushes", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 32'd0);
    tick();

    // load-use hazard
    apply(1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lu_pc_write", 32'(bus.pc_write), 32'd0);
    check("lu_bubble", 32'(bus.id_ex_bubble), 32'd1);
    tick();
    idle();
    check("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
    check("lu_released", 32'(bus.pc_write), 32'd1);
    tick();
    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lu_r0_pc_write", 32'(bus.pc_write), 32'd1);
    tick();

    // memory wait of three cycles
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("mw_stall", 32'(bus.ex_mem_stall), 32'd1);
      tick();
    end
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mw_release", 32'(bus.ex_mem_stall), 32'd0);
    check("mw_stall_cnt", 32'(bus.stall_cnt), 32'd3);
    check("mw_mem_err", 32'(bus.mem_err), 32'd0);
    tick();
    idle();
    tick();

    // taken branch together with a load-use match
    do_reset();
    apply(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("br_pc_src", 32'(bus.pc_src), 32'd1);
    check("br_flushes", 32'({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush}), 32'd7);
    check("br_bubble", 32'(bus.id_ex_bubble), 32'd0);
    tick();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    check("br_nottaken", 32'(bus.if_id_flush), 32'd0);
    tick();

    // branch held behind a store waiting on memory
    do_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      check("bw_noflush", 32'(bus.if_id_flush), 32'd0);
      tick();
    end
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("bw_flush", 32'(bus.if_id_flush), 32'd1);
    check("bw_pc_src", 32'(bus.pc_src), 32'd1);
    tick();
    idle();
    check("bw_flush_cnt", 32'(bus.flush_cnt), 32'd1);
    tick();

    // timeout into ERR
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("to_no_err_yet", 32'(bus.mem_err), 32'd0);
      tick();
    end
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_mem_err", 32'(bus.mem_err), 32'd1);
    check("to_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("to_frozen", 32'(bus.pc_write), 32'd0);
    tick();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("to_sticky", 32'({bus.mem_err, bus.pc_write, bus.if_id_flush}), 32'd4);
    tick();
    do_reset();
    idle();
    check("to_cleared", 32'({bus.mem_err, bus.pc_write}), 32'd1);
    tick();

    // reset in the middle of a wait
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    do_reset();
    idle();
    check("midwait_run", 32'({bus.pc_write, bus.ex_mem_stall}), 32'd2);
    tick();

    // stall counter saturation
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    idle();
    check("sat_stall_cnt", 32'(bus.stall_cnt), 32'(CNT_MAX));
    tick();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      apply($urandom_range(0, 2) == 0,
            regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
            regs[$urandom_range(0, 3)],
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
